// File: rtl/jt10_adpcmb_fetch.sv
// ADPCM-B sample fetch: two-byte prefetch buffer between the ADPCM-B address
// counter and the shared ROM port, handing one 4-bit code to the decoder per cen.
module jt10_adpcmb_fetch #(
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic [AW-1:0] addr,
    input  logic          nibble_sel,
    input  logic          chon,
    input  logic          restart,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic [3:0]    data_nib,
    output logic          data_valid,
    output logic          underrun,
    input  logic          clr_underrun
);

    // state | meaning
    // IDLE  | decide whether the current or the next byte needs fetching
    // REQ   | rom_cs high, rom_addr held until rom_ok
    // GAP   | one idle cycle between requests
    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t        st, st_nx;

    logic [AW-1:0] cur_tag, nxt_tag;
    logic [7:0]    cur_byte, nxt_byte;
    logic          cur_v, nxt_v;
    logic          target_nxt;

    logic [AW-1:0] nxt_addr;
    logic          flush, cur_match, promote, capture;
    logic          issue_cur, issue_nxt, und_set;

    assign nxt_addr  = addr + AW'(1);
    assign flush     = !chon || restart;
    assign cur_match = cur_v && (cur_tag == addr);
    assign promote   = (cur_tag != addr) && nxt_v && (nxt_tag == addr);
    assign capture   = (st == REQ) && rom_ok;
    assign und_set   = cen && !(chon && cur_match) && chon && !restart;

    always_comb begin
        st_nx     = st;
        issue_cur = 1'b0;
        issue_nxt = 1'b0;
        case (st)
            IDLE: begin
                if (!flush && !cur_match && !promote)
                    issue_cur = 1'b1;
                else if (!flush && cur_match && (!nxt_v || nxt_tag != nxt_addr))
                    issue_nxt = 1'b1;
                if (issue_cur || issue_nxt)
                    st_nx = REQ;
            end
            REQ:     if (rom_ok) st_nx = GAP;
            GAP:     st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            rom_addr   <= '0;
            rom_cs     <= 1'b0;
            target_nxt <= 1'b0;
            cur_tag    <= '0;
            cur_byte   <= '0;
            cur_v      <= 1'b0;
            nxt_tag    <= '0;
            nxt_byte   <= '0;
            nxt_v      <= 1'b0;
            data_nib   <= '0;
            data_valid <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            st <= st_nx;

            if (issue_cur) begin
                rom_addr   <= addr;
                target_nxt <= 1'b0;
                rom_cs     <= 1'b1;
            end else if (issue_nxt) begin
                rom_addr   <= nxt_addr;
                target_nxt <= 1'b1;
                rom_cs     <= 1'b1;
            end
            if (capture)
                rom_cs <= 1'b0;

            if (promote) begin
                cur_tag  <= nxt_tag;
                cur_byte <= nxt_byte;
                cur_v    <= nxt_v;
                nxt_v    <= 1'b0;
            end

            // a returning byte overrides promotion for the slot it targets
            if (capture) begin
                if (target_nxt) begin
                    nxt_tag  <= rom_addr;
                    nxt_byte <= rom_data;
                    nxt_v    <= !flush;
                end else begin
                    cur_tag  <= rom_addr;
                    cur_byte <= rom_data;
                    cur_v    <= !flush;
                end
            end

            if (flush) begin
                cur_v <= 1'b0;
                nxt_v <= 1'b0;
            end

            if (cen) begin
                if (chon && cur_match) begin
                    data_nib   <= nibble_sel ? cur_byte[3:0] : cur_byte[7:4];
                    data_valid <= 1'b1;
                end else begin
                    data_nib   <= '0;
                    data_valid <= 1'b0;
                end
            end

            if (clr_underrun)
                underrun <= 1'b0;
            if (und_set)
                underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jt10_adpcmb_fetch.sv
// Bench for jt10_adpcmb_fetch: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a slot/queue level reference model.
module tb_jt10_adpcmb_fetch;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst, cen, nibble_sel, chon, restart, clr_underrun;
    logic [AW-1:0] addr;
    logic [AW-1:0] rom_addr;
    logic          rom_cs;
    logic [7:0]    rom_data;
    logic          rom_ok;
    logic [3:0]    data_nib;
    logic          data_valid, underrun;

    logic          auto_ok, man_ok;
    logic [7:0]    auto_data, man_data;
    assign rom_ok   = auto_ok | man_ok;
    assign rom_data = man_ok ? man_data : auto_data;

    always #5 clk = ~clk;

    jt10_adpcmb_fetch #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .cen(cen), .addr(addr), .nibble_sel(nibble_sel),
        .chon(chon), .restart(restart), .rom_addr(rom_addr), .rom_cs(rom_cs),
        .rom_data(rom_data), .rom_ok(rom_ok), .data_nib(data_nib),
        .data_valid(data_valid), .underrun(underrun), .clr_underrun(clr_underrun)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;
    bit resp_en = 0;
    bit spur = 0;
    int resp_max = 2;
    logic [23:0] req_log[$];

    function automatic logic [7:0] rom_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hB5;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] logv(input int i);
        return (req_log.size() > i) ? 32'(req_log[i]) : 32'hDEADBEEF;
    endfunction

    // ROM responder: answers a pending request after a random delay
    initial begin
        int cnt, dly;
        cnt = 0; dly = 0; auto_ok = 1'b0; auto_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rom_cs === 1'b1 && resp_en) begin
                if (cnt >= dly) begin
                    auto_ok   = 1'b1;
                    auto_data = rom_byte(rom_addr);
                    cnt = 0;
                    dly = $urandom_range(0, resp_max);
                end else begin
                    auto_ok = 1'b0;
                    cnt++;
                end
            end else begin
                cnt = 0;
                auto_ok   = spur ? ($urandom_range(0, 3) == 0) : 1'b0;
                auto_data = 8'($urandom);
            end
        end
    end

    // Reference model: two tagged slots plus a busy/gap pair for the ROM port
    typedef struct {
        logic [23:0] tag;
        logic [7:0]  b;
        bit          v;
    } slot_t;

    slot_t       m_cur, m_nxt;
    bit          m_busy, m_gap, m_tnxt, m_valid, m_und;
    logic [23:0] m_raddr;
    logic [3:0]  m_nib;

    initial begin
        slot_t c, n, s;
        bit flush, hit, promote;
        logic [23:0] na;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_cur = '{24'h0, 8'h0, 1'b0};
                m_nxt = '{24'h0, 8'h0, 1'b0};
                m_busy = 0; m_gap = 0; m_tnxt = 0; m_raddr = 0;
                m_nib = 0; m_valid = 0; m_und = 0;
            end else begin
                flush = !chon || restart;
                na = addr + 24'd1;
                c = m_cur;
                n = m_nxt;
                hit = c.v && (c.tag == addr);
                if (cen) begin
                    if (chon && hit) begin
                        m_nib = nibble_sel ? c.b[3:0] : c.b[7:4];
                        m_valid = 1;
                    end else begin
                        m_nib = 0;
                        m_valid = 0;
                    end
                end
                if (clr_underrun) m_und = 0;
                if (cen && !hit && chon && !restart) m_und = 1;
                promote = (c.tag != addr) && n.v && (n.tag == addr);
                if (promote) begin
                    m_cur = n;
                    m_nxt.v = 0;
                end
                if (m_busy) begin
                    if (rom_ok) begin
                        s.tag = m_raddr; s.b = rom_data; s.v = !flush;
                        if (m_tnxt) m_nxt = s; else m_cur = s;
                        m_busy = 0;
                        m_gap = 1;
                    end
                end else if (m_gap) begin
                    m_gap = 0;
                end else if (!flush) begin
                    if (!hit && !promote) begin
                        m_raddr = addr; m_tnxt = 0; m_busy = 1;
                    end else if (hit && (!n.v || n.tag != na)) begin
                        m_raddr = na; m_tnxt = 1; m_busy = 1;
                    end
                end
                if (flush) begin
                    m_cur.v = 0;
                    m_nxt.v = 0;
                end
            end
        end
    end

    // Compare process and request logger
    initial begin
        bit prev_cs;
        prev_cs = 0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("m_rom_cs", 32'(rom_cs), 32'(m_busy));
                if (m_busy) check("m_rom_addr", 32'(rom_addr), 32'(m_raddr));
                check("m_data_nib", 32'(data_nib), 32'(m_nib));
                check("m_data_valid", 32'(data_valid), 32'(m_valid));
                check("m_underrun", 32'(underrun), 32'(m_und));
                if (rom_cs === 1'b1 && !prev_cs) req_log.push_back(rom_addr);
                prev_cs = (rom_cs === 1'b1);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cs(input string nm, input logic lvl, input int lim);
        for (int i = 0; i < lim && rom_cs !== lvl; i++) @(negedge clk);
        check(nm, 32'(rom_cs), 32'(lvl));
    endtask

    task automatic cen_pulse(input logic sel);
        cen = 1'b1; nibble_sel = sel;
        step(1);
        cen = 1'b0;
        step(1);
    endtask

    initial begin
        rst = 1; cen = 0; nibble_sel = 0; chon = 0; restart = 0; clr_underrun = 0;
        addr = '0; man_ok = 0; man_data = 8'h00;
        step(1);
        chk_en = 1;
        step(2);

        // reset in the middle of a request
        rst = 0; chon = 1; addr = 24'h001000;
        wait_cs("rst_enter_req", 1'b1, 20);
        rst = 1;
        step(3);
        check("rst_rom_cs", 32'(rom_cs), 32'h0);
        check("rst_data_nib", 32'(data_nib), 32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_underrun", 32'(underrun), 32'h0);
        rst = 0; chon = 0; man_ok = 1; man_data = 8'h77;
        step(1);
        man_ok = 0;
        step(2);
        req_log.delete();
        chon = 1;
        cen_pulse(1'b0);
        check("rst_slot_invalid", 32'(data_valid), 32'h0);
        check("rst_then_underrun", 32'(underrun), 32'h1);
        clr_underrun = 1;
        step(1);
        clr_underrun = 0;

        // basic fetch of 0x1000 -> 0xA5 and prefetch of 0x1001
        resp_en = 1; resp_max = 2;
        step(16);
        check("fetch_req0", logv(0), 32'h001000);
        check("fetch_req1", logv(1), 32'h001001);
        cen_pulse(1'b0);
        check("fetch_hi", 32'(data_nib), 32'hA);
        check("fetch_valid", 32'(data_valid), 32'h1);
        cen_pulse(1'b1);
        check("fetch_lo", 32'(data_nib), 32'h5);

        // promotion of 0x1001 (byte 0xA4)
        req_log.delete();
        addr = 24'h001001;
        step(1);
        cen_pulse(1'b1);
        check("promo_lo", 32'(data_nib), 32'h4);
        check("promo_valid", 32'(data_valid), 32'h1);
        check("promo_no_underrun", 32'(underrun), 32'h0);
        step(10);
        check("promo_next_req", logv(0), 32'h001002);

        // wrap 0xFFFFFF -> 0x000000 (bytes 0x4A, 0xB5)
        req_log.delete();
        addr = 24'hFFFFFF;
        step(20);
        check("wrap_req0", logv(0), 32'hFFFFFF);
        check("wrap_req1", logv(1), 32'h000000);
        cen_pulse(1'b0);
        check("wrap_ff_hi", 32'(data_nib), 32'h4);
        addr = 24'h000000;
        step(1);
        cen_pulse(1'b0);
        check("wrap_0_hi", 32'(data_nib), 32'hB);
        check("wrap_0_valid", 32'(data_valid), 32'h1);

        // underrun with the ROM withheld
        step(12);
        resp_en = 0;
        addr = 24'h002000;
        clr_underrun = 1;
        step(1);
        clr_underrun = 0;
        for (int i = 0; i < 2000; i++) begin
            cen = (i % 20 == 0);
            step(1);
        end
        cen = 0;
        step(1);
        check("und_set", 32'(underrun), 32'h1);
        check("und_nib", 32'(data_nib), 32'h0);
        check("und_valid", 32'(data_valid), 32'h0);
        check("und_cs_held", 32'(rom_cs), 32'h1);
        clr_underrun = 1; cen = 1;
        step(1);
        clr_underrun = 0; cen = 0;
        step(1);
        check("und_set_wins", 32'(underrun), 32'h1);

        // flush while a request is outstanding
        resp_en = 1;
        step(20);
        resp_en = 0;
        req_log.delete();
        addr = 24'h003000;
        wait_cs("flush_req", 1'b1, 10);
        chon = 0;
        step(3);
        check("flush_cs_held", 32'(rom_cs), 32'h1);
        check("flush_addr_held", 32'(rom_addr), 32'h003000);
        resp_en = 1;
        wait_cs("flush_cs_drop", 1'b0, 10);
        step(5);
        check("flush_no_new_req", 32'(req_log.size()), 32'h1);
        req_log.delete();
        chon = 1;
        step(8);
        check("flush_refetch", logv(0), 32'h003000);
        cen_pulse(1'b0);
        check("flush_refetch_hi", 32'(data_nib), 32'(rom_byte(24'h003000) >> 4));

        // randomized traffic
        spur = 1; resp_max = 4;
        for (int i = 0; i < 3000; i++) begin
            int r;
            rst = ($urandom_range(0, 499) == 0);
            chon = ($urandom_range(0, 15) != 0);
            restart = ($urandom_range(0, 31) == 0);
            cen = ($urandom_range(0, 5) == 0);
            nibble_sel = 1'($urandom);
            clr_underrun = ($urandom_range(0, 49) == 0);
            r = $urandom_range(0, 99);
            if (r < 8) addr = addr + 24'd1;
            else if (r < 10) addr = 24'($urandom);
            else if (r < 11) addr = 24'hFFFFFF;
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jt10_adpcmb_fetch.md
Name: jt10_adpcmb_fetch

Overview:
- Sample-ROM responder for the ADPCM-B address counter. It takes the counter's byte address, nibble select and channel-on flag, and fetches bytes from the ADPCM-B ROM/SDRAM port over a req/ok handshake.
- Holds a 2-entry prefetch buffer (current byte, next byte) and returns the selected 4-bit code to the ADPCM-B decoder on each cen.
- Sits between the ADPCM-B counter and the shared ROM arbiter.

Parameters:
- AW, 24, byte address width of counter and ROM port.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cen  in  1  ADPCM-B sample enable (~55 kHz); nibble output updates only here.
- addr  in  AW  byte address requested by the counter.
- nibble_sel  in  1  0 = high nibble [7:4], 1 = low nibble [3:0].
- chon  in  1  channel active; low flushes the buffer.
- restart  in  1  counter restart pending; flushes the buffer.
- rom_addr  out  AW  ROM byte address.
- rom_cs  out  1  ROM request.
- rom_data  in  8  ROM byte, valid when rom_ok=1.
- rom_ok  in  1  ROM acknowledge.
- data_nib  out  4  ADPCM code to decoder.
- data_valid  out  1  data_nib came from a valid buffered byte.
- underrun  out  1  sticky: a cen found the current byte missing while chon=1.
- clr_underrun  in  1  clears underrun.

Behaviour:
- Reset (rst=1): rom_cs=0, rom_addr=0, data_nib=0, data_valid=0, underrun=0, both slots invalid, FSM=IDLE. Reset mid-request abandons the request; a rom_ok arriving after reset is ignored.
- Slots: cur{tag,byte,v} and nxt{tag,byte,v}. nxt_addr = addr+1 mod 2^AW, so 0xFFFFFF wraps to 0.
- Promotion, every clk: if cur.tag!=addr and nxt.v and nxt.tag==addr, then cur<=nxt and nxt.v<=0 in that cycle.
- Flush: when chon=0 or restart=1, cur.v and nxt.v are cleared every cycle.
- FSM IDLE:
  - If chon=1, restart=0 and (!cur.v or cur.tag!=addr) and no promotion is possible this cycle: rom_addr<=addr, target=CUR, go to REQ.
  - Else if chon=1, restart=0, cur valid for addr, and (!nxt.v or nxt.tag!=nxt_addr): rom_addr<=nxt_addr, target=NXT, go to REQ.
- FSM REQ: rom_cs=1. rom_addr is held stable until a cycle with rom_ok=1; no abort.
- On rom_ok=1:
  - Write rom_data and tag=rom_addr into the target slot and set v=1.
  - If chon=0 or restart=1 in that cycle, discard the data (v stays 0).
  - rom_cs<=0, go to GAP.
- FSM GAP: one cycle with rom_cs=0, then IDLE. Minimum spacing between requests is 2 cycles.
- rom_ok while rom_cs=0 is ignored.
- Output, on cen only:
  - If chon=1 and cur.v and cur.tag==addr: data_nib <= nibble_sel ? byte[3:0] : byte[7:4]; data_valid<=1.
  - Else: data_nib<=0, data_valid<=0. If chon=1 and restart=0, also set underrun<=1.
- data_nib is registered: it reflects the addr/nibble_sel sampled on that cen, so latency from cen to output is 1 clk.
- underrun: if clr_underrun and a set occur in the same cycle, set wins.
- Fetch latency with rom_ok answered k cycles after rom_cs rises: cur valid k+2 cycles after addr changes (1 IDLE decision + k + capture).

Test Plan:
- Reset: rst=1 for 3 clks during REQ with rom_cs=1 -> rom_cs=0, data_nib=0, data_valid=0, underrun=0. A rom_ok one cycle later is ignored and both slots stay invalid.
- Basic fetch: chon=1, addr=0x001000, ROM returns 0xA5 after 2 cycles; cen with nibble_sel=0 then 1 -> data_nib 0xA then 0x5, data_valid=1. Next request has rom_addr=0x001001.
- Prefetch/promotion: after 0x1000 and 0x1001 are buffered, addr steps to 0x001001 -> cur holds 0x1001's byte in the same cycle with no underrun, and the next rom_addr is 0x001002.
- Wrap: addr=0xFFFFFF valid -> prefetch rom_addr=0x000000; step addr to 0 -> promotion works.
- Underrun: rom_ok withheld 2000 clks, cen at 55 kHz -> underrun=1, data_nib=0, data_valid=0. Pulse clr_underrun in the same cycle as another set -> underrun stays 1.
- Flush: chon drops while in REQ -> rom_cs stays high until rom_ok, data is discarded, GAP then IDLE with no new request; chon=1 again -> refetch from addr.
